ahb_lite_sram_slave: RTL and testbench

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

---
 rtl/ahb_lite_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave with programmable wait states and byte-lane writes.
// Define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [1:0]        lsb_reg;
  logic              write_reg;
  logic [2:0]        size_reg;

  logic              start;
  logic              err_det;
  logic [3:0]        be;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;

  logic [3:0][7:0]   mem [DEPTH];
  logic [31:0]       rdata_reg;
  logic [31:0]       fwd_data_reg;
  logic [3:0]        fwd_mask_reg;
  logic [31:0]       rdata_merged;

  logic              unused_htrans;
  assign unused_htrans = &{1'b0, HTRANS[0]};

  // A new address phase is only taken while this slave is presenting ready.
  assign start = HSEL && HREADY && HTRANS[1] &&
                 (state_reg inside {ST_IDLE, ST_DONE, ST_ERR2});

`ifdef AHB_SRAM_ERR_EN
  assign err_det = (HSIZE > 3'b010) ||
                   ((HSIZE == 3'b001) && HADDR[0]) ||
                   ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) ||
                   (|HADDR[31:ADDR_W+2]);
`else
  logic unused_haddr;
  assign unused_haddr = &{1'b0, HADDR[31:ADDR_W+2]};
  assign err_det      = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (start) begin
          if (err_det) begin
            state_next = ST_ERR1;
          end else if (WS == 4'd0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WS;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = '0;
    case (state_reg)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      ST_ERR2: HRESP = 2'b01;
      ST_DONE: if (!write_reg) HRDATA = rdata_merged;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_reg   <= '0;
      lsb_reg   <= '0;
      write_reg <= 1'b0;
      size_reg  <= 3'b000;
    end else if (start) begin
      idx_reg   <= HADDR[ADDR_W+1:2];
      lsb_reg   <= HADDR[1:0];
      write_reg <= HWRITE;
      size_reg  <= HSIZE;
    end
  end

  // Oversized transfers fall through to a full-word access.
  always_comb begin
    be = 4'b1111;
    case (size_reg)
      3'b000:  be = 4'b0001 << lsb_reg;
      3'b001:  be = lsb_reg[1] ? 4'b1100 : 4'b0011;
      default: ;
    endcase
  end

  assign wr_en  = (state_reg == ST_DONE) && write_reg;
  assign rd_en  = (state_next == ST_DONE) && !(start ? HWRITE : write_reg);
  assign rd_idx = start ? HADDR[ADDR_W+1:2] : idx_reg;

  always_ff @(posedge HCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) mem[idx_reg][b] <= HWDATA[8*b +: 8];
    end
    if (rd_en) rdata_reg <= mem[rd_idx];
  end

  // The RAM reads old data when a write to the same word closes on the same edge,
  // so remember which lanes were written and patch them in on the way out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_mask_reg <= '0;
      fwd_data_reg <= '0;
    end else if (rd_en) begin
      fwd_mask_reg <= (wr_en && (idx_reg == rd_idx)) ? be : 4'b0000;
      fwd_data_reg <= HWDATA;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_merged[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                        : rdata_reg[8*gi +: 8];
    end
  endgenerate

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave: one DUT with one wait state, one with none.
module tb_ahb_lite_sram_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hresetn;
  logic        hsel;
  logic        dsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic        hsel1, hsel0, hready;
  logic        hreadyout1, hreadyout0;
  logic [31:0] hrdata1, hrdata0, m_hrdata;
  logic [1:0]  hresp1, hresp0, m_hresp;

  assign hsel1    = hsel & ~dsel;
  assign hsel0    = hsel & dsel;
  assign hready   = hreadyout1 & hreadyout0;
  assign m_hrdata = dsel ? hrdata0 : hrdata1;
  assign m_hresp  = dsel ? hresp0 : hresp1;

  ahb_lite_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) u_dut (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout1), .HRDATA(hrdata1), .HRESP(hresp1)
  );

  ahb_lite_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout0), .HRDATA(hrdata0), .HRESP(hresp0)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    logic [1:0]  exp_resp;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Data-phase monitor: counts stall cycles and checks each completed transfer.
  bit mon_active = 1'b0;
  int mon_stalls = 0;
  always @(negedge clk) begin
    if (!hresetn) begin
      mon_active = 1'b0;
      mon_stalls = 0;
    end else begin
      if (mon_active) begin
        if (!hready) begin
          mon_stalls++;
          if (sb_q.size() > 0) check("stall_hresp", {30'd0, m_hresp}, {30'd0, sb_q[0].exp_resp});
        end else begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: data phase completed with no expected entry");
          end else begin
            mon_e = sb_q.pop_front();
            check("stall_count", mon_stalls, mon_e.exp_stalls);
            check("hresp", {30'd0, m_hresp}, {30'd0, mon_e.exp_resp});
            check(mon_e.is_read ? "read_data" : "hrdata_on_write", m_hrdata,
                  mon_e.is_read ? mon_e.exp_rdata : 32'h0);
          end
          mon_active = 1'b0;
          mon_stalls = 0;
        end
      end
      if (hsel && hready && htrans[1]) begin
        mon_active = 1'b1;
        mon_stalls = 0;
      end
    end
  end

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'b010;
  endtask

  task automatic push_exp(input bit wr, input logic [31:0] exp_rd, input logic [1:0] exp_resp);
    sb_t e;
    e.is_read    = !wr;
    e.exp_rdata  = exp_rd;
    e.exp_resp   = exp_resp;
    e.exp_stalls = (exp_resp == 2'b01) ? 1 : (dsel ? 0 : 1);
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(input string what);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hready && n < 40);
    if (!hready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: hready still 0 after %0d cycles, want 1", what, n);
    end
  endtask

  task automatic xfer(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic [1:0] exp_resp);
    push_exp(wr, exp_rd, exp_resp);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = addr;
    wait_ready("addr");
    @(posedge clk); #1;
    idle_bus();
    hwdata = wd;
    wait_ready("data");
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];
  vec_t pipe[5];

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 3'b000, 32'h23, 32'hAA000000, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hAA223344};
    vecs[5]  = '{1'b1, 3'b001, 32'h22, 32'h55660000, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h55663344};
    vecs[7]  = '{1'b1, 3'b000, 32'h21, 32'h00007700, 32'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h55667744};
    vecs[9]  = '{1'b1, 3'b000, 32'h20, 32'h000000CC, 32'h0};
    vecs[10] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h556677CC};
    vecs[11] = '{1'b1, 3'b010, 32'h24, 32'h01020304, 32'h0};
    vecs[12] = '{1'b1, 3'b001, 32'h24, 32'hFFFF9999, 32'h0};
    vecs[13] = '{1'b0, 3'b010, 32'h24, 32'h0,        32'h01029999};
    vecs[14] = '{1'b0, 3'b000, 32'h23, 32'h0,        32'h556677CC};

    pipe[0] = '{1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0};
    pipe[1] = '{1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D};
    pipe[2] = '{1'b1, 3'b010, 32'h44, 32'h11111111, 32'h0};
    pipe[3] = '{1'b1, 3'b000, 32'h45, 32'h00002200, 32'h0};
    pipe[4] = '{1'b0, 3'b010, 32'h44, 32'h0,        32'h11112211};

    // Reset state
    hresetn = 1'b0;
    dsel    = 1'b0;
    hwdata  = 32'h0;
    idle_bus();
    @(posedge clk); @(posedge clk); #1;
    check("reset_hreadyout_ws1", {31'd0, hreadyout1}, 32'd1);
    check("reset_hresp_ws1", {30'd0, hresp1}, 32'd0);
    check("reset_hrdata_ws1", hrdata1, 32'h0);
    check("reset_hreadyout_ws0", {31'd0, hreadyout0}, 32'd1);
    check("reset_hrdata_ws0", hrdata0, 32'h0);
    hresetn = 1'b1;
    @(posedge clk); #1;

    // Table-driven single transfers on the one-wait-state slave
    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, 2'b00);
    end

    // IDLE and BUSY transfers with HWRITE=1 must not touch memory
    hsel   = 1'b1;
    hwrite = 1'b1;
    haddr  = 32'h10;
    hsize  = 3'b010;
    hwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      htrans = (i == 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      check("idle_hreadyout", {31'd0, hreadyout1}, 32'd1);
      check("idle_hresp", {30'd0, hresp1}, 32'd0);
      check("idle_hrdata", hrdata1, 32'h0);
      @(posedge clk); #1;
    end
    idle_bus();
    xfer(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);

    // Misaligned word write
    xfer(1'b1, 3'b010, 32'h00, 32'h55AA55AA, 32'h0, 2'b00);
`ifdef AHB_SRAM_ERR_EN
    xfer(1'b1, 3'b010, 32'h02, 32'h12345678, 32'h0, 2'b01);
    xfer(1'b0, 3'b010, 32'h00, 32'h0, 32'h55AA55AA, 2'b00);
    xfer(1'b1, 3'b010, 32'h1000, 32'h87654321, 32'h0, 2'b01);
    xfer(1'b1, 3'b011, 32'h00, 32'h87654321, 32'h0, 2'b01);
    xfer(1'b0, 3'b010, 32'h00, 32'h0, 32'h55AA55AA, 2'b00);
`else
    xfer(1'b1, 3'b010, 32'h02, 32'h12345678, 32'h0, 2'b00);
    xfer(1'b0, 3'b010, 32'h00, 32'h0, 32'h12345678, 2'b00);
`endif

    // Reset asserted in the middle of a write's wait state
    xfer(1'b1, 3'b010, 32'h30, 32'h0BADF00D, 32'h0, 2'b00);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h30;
    @(posedge clk); #1;
    check("wait_hreadyout_before_reset", {31'd0, hreadyout1}, 32'd0);
    idle_bus();
    hwdata = 32'h12345678;
    #2;
    hresetn = 1'b0;
    #1;
    check("async_reset_hreadyout", {31'd0, hreadyout1}, 32'd1);
    check("async_reset_hresp", {30'd0, hresp1}, 32'd0);
    check("async_reset_hrdata", hrdata1, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    hresetn = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 3'b010, 32'h30, 32'h0, 32'h0BADF00D, 2'b00);

    // Back-to-back pipelined transfers on the zero-wait-state slave
    dsel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_exp(pipe[i].wr, pipe[i].exp_rd, 2'b00);
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = pipe[i].wr;
      hsize  = pipe[i].sz;
      haddr  = pipe[i].addr;
      hwdata = (i > 0) ? pipe[i-1].wd : 32'h0;
      @(posedge clk); #1;
    end
    idle_bus();
    hwdata = pipe[4].wd;
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
